// File: rtl/capture_ctrl.sv
// Capture controller: circular pre-trigger history, post-trigger delay count,
// then newest-first readback of the stored samples through a send/busy handshake.
module capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wrSize,
    input  logic [31:0]           config_data,
    input  logic                  arm,
    input  logic                  run,
    input  logic                  abort,
    input  logic                  validIn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  busy,
    input  logic [DATA_WIDTH-1:0] memRdData,
    output logic                  send,
    output logic [DATA_WIDTH-1:0] sendData,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWrData,
    output logic                  memWrite,
    output logic                  memRead,
    output logic                  capturing,
    output logic                  done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Truncation is harmless: a wider DEPTH-1 only saturates at the counter max.
    localparam logic [CNT_WIDTH-1:0] IDX_MAX = CNT_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, SAMPLE, DELAY, READ, RDWAIT, SEND, BUSYWAIT
    } state_t;

    state_t state, next_state;

    logic [CNT_WIDTH-1:0]  cfg_read, cfg_delay;
    logic [CNT_WIDTH-1:0]  read_lim, delay_lim;
    logic [CNT_WIDTH-1:0]  post_cnt, idx;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  rd_pend;

    logic in_capture, wr_en, post_en, trig_end, last;
    logic capturing_d, send_d, done_d, mem_read_d;

    assign in_capture = (state == SAMPLE) || (state == DELAY);
    assign wr_en      = in_capture && validIn;
    assign post_en    = wr_en && ((state == DELAY) || run);
    assign trig_end   = post_en && (post_cnt == delay_lim);
    assign last       = (idx == read_lim) || (idx == IDX_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (arm) next_state = SAMPLE;
            SAMPLE: begin
                if (abort || trig_end) next_state = READ;
                else if (run)          next_state = DELAY;
            end
            DELAY:    if (abort || trig_end) next_state = READ;
            READ:     next_state = RDWAIT;
            RDWAIT:   next_state = SEND;
            SEND:     if (!busy) next_state = BUSYWAIT;
            BUSYWAIT: if (!busy) next_state = last ? IDLE : READ;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        capturing_d = (next_state == SAMPLE) || (next_state == DELAY);
        send_d      = (state == SEND) && !busy;
        done_d      = (state == BUSYWAIT) && !busy && last;
        mem_read_d  = (state == READ);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_read  <= '0;
            cfg_delay <= '0;
            read_lim  <= '0;
            delay_lim <= '0;
            post_cnt  <= '0;
            idx       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            send      <= 1'b0;
            sendData  <= '0;
            memAddr   <= '0;
            memWrData <= '0;
            memWrite  <= 1'b0;
            memRead   <= 1'b0;
            capturing <= 1'b0;
            done      <= 1'b0;
        end else begin
            capturing <= capturing_d;
            send      <= send_d;
            done      <= done_d;
            memWrite  <= wr_en;
            memRead   <= mem_read_d;
            rd_pend   <= memRead;
            if (wrSize) begin
                cfg_read  <= config_data[CNT_WIDTH-1:0];
                cfg_delay <= config_data[16 +: CNT_WIDTH];
            end
            if (state == IDLE && arm) begin
                read_lim  <= cfg_read;
                delay_lim <= cfg_delay;
                post_cnt  <= '0;
            end
            if (post_en) post_cnt <= post_cnt + 1'b1;
            if (wr_en) begin
                memAddr   <= wr_ptr;
                memWrData <= dataIn;
                wr_ptr    <= wr_ptr + 1'b1;
            end else if (state == READ) begin
                memAddr <= rd_ptr;
            end
            // Newest sample is the one landing this cycle, if any.
            if (in_capture && next_state == READ) begin
                rd_ptr <= wr_en ? wr_ptr : wr_ptr - 1'b1;
                idx    <= '0;
            end
            if (state == BUSYWAIT && !busy && !last) begin
                rd_ptr <= rd_ptr - 1'b1;
                idx    <= idx + 1'b1;
            end
            // Read data arrives one cycle after the strobe.
            if (rd_pend) sendData <= memRdData;
        end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl (8-word memory) with send/write scoreboards.
module tb_capture_ctrl;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wrSize = 1'b0, arm = 1'b0, run = 1'b0, abort = 1'b0;
    logic        validIn = 1'b0, busy = 1'b0;
    logic [31:0] config_data = '0, dataIn = '0, memRdData = '0;
    logic        send, done, memWrite, memRead, capturing;
    logic [31:0] sendData, memWrData;
    logic [AW-1:0] memAddr;

    logic [31:0] ram [DEPTH] = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002,
        32'hDEAD0003, 32'hDEAD0004, 32'hDEAD0005, 32'hDEAD0006, 32'hDEAD0007};
    logic [31:0] ref_mem [DEPTH] = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002,
        32'hDEAD0003, 32'hDEAD0004, 32'hDEAD0005, 32'hDEAD0006, 32'hDEAD0007};

    logic [31:0]   exp_send[$];
    logic [31:0]   exp_wdata[$];
    logic [AW-1:0] exp_waddr[$];

    int errs = 0, chks = 0;
    int wp = 0, mphase = 0, post = 0;
    int m_rc = 0, m_dc = 0, cfg_rc = 0, cfg_dc = 0;
    int done_cnt = 0, send_cnt = 0, cyc = 0, last_send = -100;

    always #5 clock = ~clock;

    capture_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .wrSize(wrSize),
        .config_data(config_data), .arm(arm), .run(run), .abort(abort),
        .validIn(validIn), .dataIn(dataIn), .busy(busy),
        .memRdData(memRdData), .send(send), .sendData(sendData),
        .memAddr(memAddr), .memWrData(memWrData), .memWrite(memWrite),
        .memRead(memRead), .capturing(capturing), .done(done)
    );

    always @(posedge clock) begin
        if (memWrite) ram[memAddr] <= memWrData;
        if (memRead)  memRdData    <= ram[memAddr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        cyc++;
        if (reset) return;
        if (send) begin
            check("send_gap", 32'(cyc - last_send >= 3), 1);
            check("send_busy", {31'b0, busy}, 0);
            check("send_pending", 32'(exp_send.size() > 0), 1);
            if (exp_send.size() > 0) check("send_data", sendData, exp_send.pop_front());
            last_send = cyc;
            send_cnt++;
        end
        if (memWrite) begin
            check("rd_wr_excl", {31'b0, memRead}, 0);
            check("write_pending", 32'(exp_waddr.size() > 0), 1);
            if (exp_waddr.size() > 0) begin
                check("wr_addr", 32'(memAddr), 32'(exp_waddr.pop_front()));
                check("wr_data", memWrData, exp_wdata.pop_front());
            end
        end
        if (done) begin
            check("done_early", exp_send.size(), 0);
            done_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        monitor();
    endtask

    task automatic model_step(input logic v, input logic [31:0] d,
                              input logic r, input logic ab);
        logic fin;
        int n;
        if (mphase != 1 && mphase != 2) return;
        fin = ab;
        if (v) begin
            exp_waddr.push_back(AW'(wp));
            exp_wdata.push_back(d);
            ref_mem[wp] = d;
            wp = (wp + 1) % DEPTH;
            if ((mphase == 2 || r) && !fin) begin
                if (post == m_dc) fin = 1'b1;
                post++;
            end
        end
        if (fin) begin
            n = (m_rc + 1 < DEPTH) ? m_rc + 1 : DEPTH;
            for (int k = 0; k < n; k++)
                exp_send.push_back(ref_mem[(wp + 2 * DEPTH - 1 - k) % DEPTH]);
            mphase = 3;
        end else if (mphase == 1 && r) begin
            mphase = 2;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic r, input logic ab);
        validIn = v; dataIn = d; run = r; abort = ab;
        model_step(v, d, r, ab);
        tick();
        validIn = 1'b0; run = 1'b0; abort = 1'b0;
    endtask

    task automatic set_cfg(input int rc, input int dc);
        wrSize = 1'b1;
        config_data = {dc[15:0], rc[15:0]};
        cfg_rc = rc; cfg_dc = dc;
        tick();
        wrSize = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        if (mphase == 0) begin
            mphase = 1; post = 0; m_rc = cfg_rc; m_dc = cfg_dc;
        end
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < 400) begin
            tick();
            k++;
        end
        repeat (8) tick();
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_left"}, exp_send.size(), 0);
        mphase = 0;
    endtask

    task automatic wait_send(input string tag);
        int k = 0;
        while (!send && k < 100) begin
            tick();
            k++;
        end
        check(tag, {31'b0, send}, 1);
    endtask

    task automatic out_zero(input string tag);
        check({tag, "_send"}, {31'b0, send}, 0);
        check({tag, "_done"}, {31'b0, done}, 0);
        check({tag, "_mwr"}, {31'b0, memWrite}, 0);
        check({tag, "_mrd"}, {31'b0, memRead}, 0);
        check({tag, "_capt"}, {31'b0, capturing}, 0);
        check({tag, "_addr"}, 32'(memAddr), 0);
        check({tag, "_sdata"}, sendData, 0);
        check({tag, "_wdata"}, memWrData, 0);
    endtask

    task automatic hit_reset(input string tag);
        reset = 1'b1;
        #1;
        out_zero(tag);
        wp = 0; mphase = 0;
        exp_send.delete(); exp_waddr.delete(); exp_wdata.delete();
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        int s0, d0;
        repeat (2) tick();
        out_zero("reset");
        reset = 1'b0;
        tick();

        drive(1'b1, 32'h99, 1'b1, 1'b1);
        drive(1'b1, 32'h98, 1'b0, 1'b0);
        check("idle_capt", {31'b0, capturing}, 0);

        set_cfg(7, 3);
        do_arm();
        check("arm_capt", {31'b0, capturing}, 1);
        for (int i = 0; i < 20; i++) drive(1'b1, i, i == 10, 1'b0);
        wait_done("basic");
        check("basic_capt", {31'b0, capturing}, 0);

        set_cfg(15, 0);
        do_arm();
        s0 = send_cnt;
        for (int i = 0; i < 20; i++) drive(1'b1, 32'h100 + i, i == 19, 1'b0);
        wait_done("wrap");
        check("wrap_sends", send_cnt - s0, 8);

        set_cfg(7, 3);
        do_arm();
        s0 = send_cnt;
        for (int i = 0; i < 5; i++) drive(1'b1, i, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        wait_done("abort");
        check("abort_sends", send_cnt - s0, 8);

        set_cfg(3, 0);
        do_arm();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + i, i == 3, 1'b0);
        wait_send("busy_first");
        busy = 1'b1;
        s0 = send_cnt;
        repeat (50) tick();
        check("busy_hold", send_cnt - s0, 0);
        busy = 1'b0;
        wait_done("busy");

        set_cfg(7, 5);
        do_arm();
        drive(1'b1, 32'h400, 1'b0, 1'b0);
        drive(1'b1, 32'h401, 1'b1, 1'b0);
        drive(1'b1, 32'h402, 1'b0, 1'b0);
        check("delay_capt", {31'b0, capturing}, 1);
        hit_reset("rst_delay");
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + i, 1'b1, 1'b0);
        check("rst_run_ign", {31'b0, capturing}, 0);

        set_cfg(3, 0);
        do_arm();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h600 + i, i == 3, 1'b0);
        wait_send("rst_first");
        repeat (3) tick();
        d0 = done_cnt;
        s0 = send_cnt;
        hit_reset("rst_send");
        repeat (12) tick();
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_send", send_cnt - s0, 0);

        set_cfg(3, 3);
        do_arm();
        drive(1'b1, 32'h700, 1'b0, 1'b0);
        drive(1'b1, 32'h701, 1'b0, 1'b0);
        drive(1'b1, 32'h702, 1'b1, 1'b1);
        wait_done("run_abort");

        set_cfg(2, 1);
        do_arm();
        drive(1'b1, 32'h800, 1'b1, 1'b0);
        arm = 1'b1;
        drive(1'b1, 32'h801, 1'b0, 1'b0);
        arm = 1'b0;
        wait_done("arm_delay");
        drive(1'b1, 32'h900, 1'b0, 1'b0);
        drive(1'b1, 32'h901, 1'b0, 1'b0);
        check("arm_ignored", {31'b0, capturing}, 0);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
